tensor_operand_loader_4m4n4k: RTL and testbench

TENSOR_OPERAND_LOADER_4M4N4K -- requirements
Module: tensor_operand_loader_4m4n4k

---
 rtl/tensor_operand_loader_4m4n4k.sv | 150 +++++++++++++++
 tb/tb_tensor_operand_loader_4m4n4k.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tensor_operand_loader_4m4n4k.sv
// Operand loader for a 4x4x4 int4 crossbar: collects twelve row words (A, B, C),
// then presents them column-major on cin_* and holds start for HOLD_CYCLES cycles.
module tensor_operand_loader_4m4n4k #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_sel,
    input  logic [1:0]  in_row,
    input  logic [15:0] in_data,
    output logic [15:0] cin_M_0,
    output logic [15:0] cin_M_1,
    output logic [15:0] cin_M_2,
    output logic [15:0] cin_M_3,
    output logic [15:0] cin_N_0,
    output logic [15:0] cin_N_1,
    output logic [15:0] cin_N_2,
    output logic [15:0] cin_N_3,
    output logic [15:0] cin_K_0,
    output logic [15:0] cin_K_1,
    output logic [15:0] cin_K_2,
    output logic [15:0] cin_K_3,
    output logic        start,
    output logic        busy,
    output logic        tile_done,
    output logic        sel_err
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // [operand][row] for the buffer, [operand][column] for the cin registers.
    typedef logic [2:0][3:0][15:0] tile_t;

    state_t          state_q, state_d;
    tile_t           buf_q, buf_d;
    tile_t           cin_q, cin_d;
    logic [2:0][3:0] mask_q, mask_d;
    logic [7:0]      hold_q;
    logic            xfer;
    logic            row_xfer;
    logic            last_hold;
    logic            tile_full;

    assign xfer      = in_valid && (state_q == LOAD);
    assign row_xfer  = xfer && !flush && (in_sel != 2'd3);
    assign last_hold = (hold_q == 8'(HOLD_CYCLES - 1));
    assign tile_full = &mask_d;

    // Buffer and mask update; the completing row is folded in here so the
    // transpose below sees it on the same edge that enters RUN.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        buf_d  = buf_q;
        mask_d = mask_q;
        if (flush) begin
            buf_d  = '0;
            mask_d = '0;
        end else if (row_xfer) begin
            case (in_sel)
                2'd0: begin
                    buf_d[0][in_row]  = in_data;
                    mask_d[0][in_row] = 1'b1;
                end
                2'd1: begin
                    buf_d[1][in_row]  = in_data;
                    mask_d[1][in_row] = 1'b1;
                end
                2'd2: begin
                    buf_d[2][in_row]  = in_data;
                    mask_d[2][in_row] = 1'b1;
                end
                default: ;
            endcase
        end else if ((state_q == RUN) && last_hold) begin
            mask_d = '0;
        end
    end

    // Element (row i, col j) lands in nibble i of column word j; bits are moved untouched.
    always_comb begin
        cin_d = '0;
        for (int x = 0; x < 3; x++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    cin_d[x][j][(15 - 4 * i) -: 4] = buf_d[x][i][(15 - 4 * j) -: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) state_q <= LOAD;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (row_xfer && tile_full) state_d = RUN;
            RUN:     if (flush || last_hold)    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        start    = (state_q == RUN);
        busy     = (state_q == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: buffer and cin are plain flop banks, not RAM, so they can and must be reset.
        if (!rst) begin
            buf_q     <= '0;
            mask_q    <= '0;
            cin_q     <= '0;
            hold_q    <= '0;
            tile_done <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            mask_q <= mask_d;
            if ((state_q == LOAD) && (state_d == RUN)) cin_q <= cin_d;
            hold_q    <= ((state_q == RUN) && (state_d == RUN)) ? hold_q + 8'd1 : 8'd0;
            tile_done <= (state_q == RUN) && last_hold && !flush;
            sel_err   <= xfer && !flush && (in_sel == 2'd3);
        end
    end

    assign cin_M_0 = cin_q[0][0];
    assign cin_M_1 = cin_q[0][1];
    assign cin_M_2 = cin_q[0][2];
    assign cin_M_3 = cin_q[0][3];
    assign cin_N_0 = cin_q[1][0];
    assign cin_N_1 = cin_q[1][1];
    assign cin_N_2 = cin_q[1][2];
    assign cin_N_3 = cin_q[1][3];
    assign cin_K_0 = cin_q[2][0];
    assign cin_K_1 = cin_q[2][1];
    assign cin_K_2 = cin_q[2][2];
    assign cin_K_3 = cin_q[2][3];

endmodule

// File: tb/tb_tensor_operand_loader_4m4n4k.sv
// Directed bench for tensor_operand_loader_4m4n4k: hand-computed transposes, windows,
// shuffled/gapped loads, reserved select, flush, mid-RUN reset and back-to-back tiles.
module tb_tensor_operand_loader_4m4n4k;

    localparam int HOLD = 16;

    localparam logic [15:0] TILE [12] = '{
        16'h2D56, 16'hF493, 16'h6B1E, 16'h97C0,
        16'h3E1B, 16'hA492, 16'h5F0D, 16'hC697,
        16'h5C4B, 16'hB3D3, 16'h4D4C, 16'hB3C4
    };
    localparam logic [15:0] EXP_CIN [12] = '{
        16'h2F69, 16'hD4B7, 16'h591C, 16'h63E0,
        16'h3A5C, 16'hE4F6, 16'h1909, 16'hB2D7,
        16'h5B4B, 16'hC3D3, 16'h4D4C, 16'hB3C4
    };
    localparam int SHUF_IDX [13] = '{0, 9, 4, 11, 2, 0, 7, 5, 1, 10, 3, 8, 6};

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [1:0]  in_row;
    logic [15:0] in_data;
    logic [15:0] cin [12];
    logic        start, busy, tile_done, sel_err;

    logic [15:0] zero_rows [12];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          td_seen;

    tensor_operand_loader_4m4n4k #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_row(in_row), .in_data(in_data),
        .cin_M_0(cin[0]), .cin_M_1(cin[1]), .cin_M_2(cin[2]), .cin_M_3(cin[3]),
        .cin_N_0(cin[4]), .cin_N_1(cin[5]), .cin_N_2(cin[6]), .cin_N_3(cin[7]),
        .cin_K_0(cin[8]), .cin_K_1(cin[9]), .cin_K_2(cin[10]), .cin_K_3(cin[11]),
        .start(start), .busy(busy), .tile_done(tile_done), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [1:0] sel, input logic [1:0] row, input logic [15:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_row   = row;
        in_data  = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_tile(input logic [15:0] rows [12]);
        td_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            beat(2'(k / 4), 2'(k % 4), rows[k]);
            if (tile_done) td_seen = 1'b1;
            if (k == 10) check("pre_start", start, 1'b0);
        end
    endtask

    task automatic check_cin(input string tag, input logic [15:0] exp [12]);
        for (int k = 0; k < 12; k++)
            check($sformatf("%s_cin%0d", tag, k), cin[k], exp[k]);
    endtask

    // Called one step after the entering edge; ends one cycle after tile_done.
    task automatic run_window(input string tag);
        int n;
        n = 0;
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        while (start === 1'b1 && n < 300) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_len"}, n, HOLD);
        check({tag, "_done"}, tile_done, 1'b1);
        check({tag, "_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, tile_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  bad_ready;
        zero_rows = '{default: 16'h0000};
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_sel = 2'd0; in_row = 2'd0; in_data = 16'h0000;

        // Reset state
        idle(2);
        check("rst_ready", in_ready, 1'b1);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tile_done, 1'b0);
        check("rst_selerr", sel_err, 1'b0);
        check("rst_cin0", cin[0], 16'h0000);
        #2 rst = 1'b1;

        // Back-to-back load: start in cycle 13 for HOLD cycles
        load_tile(TILE);
        check_cin("b2b", EXP_CIN);
        run_window("b2b");

        // Shuffled order with gaps, A row0 written twice
        for (int k = 0; k < 13; k++) begin
            if (k == 12) check("shuf_pre_start", start, 1'b0);
            beat(2'(SHUF_IDX[k] / 4), 2'(SHUF_IDX[k] % 4),
                 (k == 0) ? 16'hFFFF : TILE[SHUF_IDX[k]]);
            if (k % 2 == 1) idle(1);
        end
        if (start !== 1'b1) idle(0);
        check_cin("shuf", EXP_CIN);
        run_window("shuf");

        // Reserved select mid-load
        for (int k = 0; k < 12; k++) begin
            if (k == 5) begin
                beat(2'd3, 2'd0, 16'hFFFF);
                check("selerr_pulse", sel_err, 1'b1);
                check("selerr_no_start", start, 1'b0);
            end
            beat(2'(k / 4), 2'(k % 4), TILE[k]);
            if (k == 5) check("selerr_clear", sel_err, 1'b0);
            if (k == 10) check("selerr_pre_start", start, 1'b0);
        end
        check_cin("selerr", EXP_CIN);
        run_window("selerr");

        // Flush after 7 rows with a simultaneous beat, then all-zero reload
        for (int k = 0; k < 7; k++) beat(2'(k / 4), 2'(k % 4), TILE[k]);
        flush = 1'b1;
        beat(2'd2, 2'd3, 16'hFFFF);
        flush = 1'b0;
        check("flush_no_done", tile_done, 1'b0);
        check("flush_no_start", start, 1'b0);
        check("flush_keeps_cin", cin[0], 16'h2F69);
        load_tile(zero_rows);
        check_cin("zero", zero_rows);
        run_window("zero");

        // Reset during RUN cycle 5
        load_tile(TILE);
        check("pre_rst_start", start, 1'b1);
        idle(4);
        check("pre_rst_run", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_run_start", start, 1'b0);
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_ready", in_ready, 1'b1);
        check("rst_run_cinM0", cin[0], 16'h0000);
        check("rst_run_cinK3", cin[11], 16'h0000);
        #3 rst = 1'b1;

        // First edge after release accepts; then a second tile is held off during RUN
        load_tile(TILE);
        check("post_rst_no_done", td_seen, 1'b0);
        check_cin("post_rst", EXP_CIN);
        in_valid = 1'b1; in_sel = 2'd0; in_row = 2'd0; in_data = 16'h0000;
        n = 0;
        bad_ready = 1'b0;
        while (start === 1'b1 && n < 300) begin
            if (in_ready !== 1'b0) bad_ready = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        check("hold_len", n, HOLD);
        check("hold_not_ready", bad_ready, 1'b0);
        check("hold_done", tile_done, 1'b1);
        check("hold_cin_kept", cin[0], 16'h2F69);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_done_pulse", tile_done, 1'b0);
        for (int k = 1; k < 12; k++) begin
            beat(2'(k / 4), 2'(k % 4), 16'h0000);
            if (k == 10) check("second_pre_start", start, 1'b0);
            if (k == 10) check("second_cin_kept", cin[4], 16'h3A5C);
        end
        check_cin("second", zero_rows);
        run_window("second");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
